// File: rtl/btn_mod_counter.sv
// btn_mod_counter: modulo up/down counter with prescaled tick, debounced dir/run buttons and parallel load
module btn_db #(
    parameter int DB_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    logic [1:0] sync_q, sync_d;
    logic [DB_LEN-1:0] sh_q, sh_d;
    logic clean_q, clean_d, prev_q, prev_d;
    always_comb begin
        sync_d = {sync_q[0], btn};
        sh_d = {sh_q[DB_LEN-2:0], sync_q[1]};
        clean_d = &sh_q ? 1'b1 : ~|sh_q ? 1'b0 : clean_q;
        prev_d = clean_q;
        press = clean_q & ~prev_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            sh_q <= '0;
            clean_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            sh_q <= sh_d;
            clean_q <= clean_d;
            prev_q <= prev_d;
        end
    end
endmodule

module btn_mod_counter #(
    parameter int WIDTH = 4,
    parameter int MAX_COUNT = 15,
    parameter int FAST_DIV = 2,
    parameter int SLOW_DIV = 100,
    parameter int DB_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             speed_sel,
    input  logic             dir_button,
    input  logic             run_button,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             running,
    output logic             tick,
    output logic             wrap
);
    localparam int MAX_DIV = FAST_DIV > SLOW_DIV ? FAST_DIV : SLOW_DIV;
    localparam int PW = $clog2(MAX_DIV + 1);
    localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_COUNT);
    logic [PW-1:0] pre_q, pre_d, div_m1;
    logic [WIDTH-1:0] count_q, count_d;
    logic dir_q, dir_d, running_q, running_d, tick_q, tick_d, wrap_q, wrap_d;
    logic dir_press, run_press, step;
    btn_db #(.DB_LEN(DB_LEN)) u_dir_db (.clk(clk), .reset(reset), .btn(dir_button), .press(dir_press));
    btn_db #(.DB_LEN(DB_LEN)) u_run_db (.clk(clk), .reset(reset), .btn(run_button), .press(run_press));
    // tick_d feeds the counter directly so count moves on the same edge that registers tick
    always_comb begin
        div_m1 = speed_sel ? PW'(FAST_DIV - 1) : PW'(SLOW_DIV - 1);
        tick_d = pre_q >= div_m1;
        pre_d = tick_d ? '0 : pre_q + 1'b1;
        step = tick_d & running_q;
        wrap_d = ~load & step & (dir_q ? count_q == '0 : count_q == MAXC);
        count_d = load ? (load_value > MAXC ? MAXC : load_value)
                : ~step ? count_q
                : dir_q ? (count_q == '0 ? MAXC : count_q - 1'b1)
                : (count_q == MAXC ? '0 : count_q + 1'b1);
        dir_d = dir_q ^ dir_press;
        running_d = running_q ^ run_press;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            count_q <= '0;
            dir_q <= 1'b0;
            running_q <= 1'b1;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            count_q <= count_d;
            dir_q <= dir_d;
            running_q <= running_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end
    assign count = count_q;
    assign dir = dir_q;
    assign running = running_q;
    assign tick = tick_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_btn_mod_counter.sv
// tb_btn_mod_counter: scoreboard bench comparing btn_mod_counter against a cycle model every edge
module tb_btn_mod_counter;
    localparam int W = 4, MX = 9, FD = 2, SD = 5, DB = 3;
    logic clk = 1'b0, reset = 1'b1, speed_sel = 1'b1, dir_button = 1'b0, run_button = 1'b0, load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] count;
    logic dir, running, tick, wrap;
    int checks = 0, errors = 0, ntick = 0, nwrap = 0, n, c0;
    logic [W+3:0] sb[$];
    int m_count, m_pre;
    logic m_dir, m_run, m_tick, m_wrap, cl_d, pv_d, cl_r, pv_r;
    logic [DB+1:0] hd, hr;

    btn_mod_counter #(.WIDTH(W), .MAX_COUNT(MX), .FAST_DIV(FD), .SLOW_DIV(SD), .DB_LEN(DB)) dut (
        .clk(clk), .reset(reset), .speed_sel(speed_sel), .dir_button(dir_button),
        .run_button(run_button), .load(load), .load_value(load_value), .count(count),
        .dir(dir), .running(running), .tick(tick), .wrap(wrap));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_pre = 0; m_dir = 0; m_run = 1; m_tick = 0; m_wrap = 0;
        cl_d = 0; pv_d = 0; cl_r = 0; pv_r = 0; hd = '0; hr = '0;
    endtask

    // hist[1:0] are the two synchronizer stages; the filter window sits above them
    function automatic logic filt(input logic [DB+1:0] h, input logic c);
        return (h[DB+1:2] == '1) ? 1'b1 : (h[DB+1:2] == '0) ? 1'b0 : c;
    endfunction

    task automatic model_edge();
        int div, lv;
        logic t, pd, pr;
        div = speed_sel ? FD : SD;
        lv = int'(load_value);
        t = m_pre >= div - 1;
        pd = cl_d & ~pv_d;
        pr = cl_r & ~pv_r;
        m_pre = t ? 0 : m_pre + 1;
        m_wrap = 0;
        if (load) m_count = lv > MX ? MX : lv;
        else if (t && m_run) begin
            if (!m_dir) begin
                if (m_count == MX) begin m_count = 0; m_wrap = 1; end
                else m_count = m_count + 1;
            end else begin
                if (m_count == 0) begin m_count = MX; m_wrap = 1; end
                else m_count = m_count - 1;
            end
        end
        m_tick = t;
        m_dir = m_dir ^ pd;
        m_run = m_run ^ pr;
        pv_d = cl_d; cl_d = filt(hd, cl_d); hd = {hd[DB:0], dir_button};
        pv_r = cl_r; cl_r = filt(hr, cl_r); hr = {hr[DB:0], run_button};
        sb.push_back({W'(m_count), m_dir, m_run, m_tick, m_wrap});
    endtask

    task automatic step();
        logic [W+3:0] e;
        model_edge();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("count", int'(count), int'(e[W+3:4]));
        chk("dir", int'(dir), int'(e[3]));
        chk("running", int'(running), int'(e[2]));
        chk("tick", int'(tick), int'(e[1]));
        chk("wrap", int'(wrap), int'(e[0]));
        ntick += int'(tick);
        nwrap += int'(wrap);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        chk("rst_count", int'(count), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_running", int'(running), 1);
        chk("rst_tick", int'(tick), 0);
        chk("rst_wrap", int'(wrap), 0);
        nwrap = 0;
        repeat (24) step();
        chk("wraps_in_24", nwrap, 1);
        n = 0;
        while (!(m_count == MX && m_pre == FD - 1) && n < 60) begin step(); n++; end
        chk("find_tick_at_9", int'(n < 60), 1);
        load = 1'b1; load_value = 4'd4;
        step();
        load = 1'b0;
        chk("load_on_tick_count", int'(count), 4);
        chk("load_on_tick_wrap", int'(wrap), 0);
        chk("load_on_tick_tick", int'(tick), 1);
        n = 0;
        while (m_count != 3 && n < 60) begin step(); n++; end
        chk("find_count_3", int'(n < 60), 1);
        dir_button = 1'b1;
        step();
        repeat (5) step();
        chk("dir_edge5", int'(dir), 0);
        step();
        chk("dir_edge6", int'(dir), 1);
        repeat (4) step();
        dir_button = 1'b0;
        n = 0;
        step();
        while (!wrap && n < 40) begin step(); n++; end
        chk("down_wrap_seen", int'(wrap), 1);
        chk("down_wrap_count", int'(count), MX);
        for (int i = 0; i < 10; i++) begin
            run_button = (i % 2 == 0);
            step();
        end
        chk("bounce_no_toggle", int'(running), 1);
        run_button = 1'b1;
        repeat (8) step();
        chk("run_stopped", int'(running), 0);
        c0 = int'(count);
        ntick = 0;
        repeat (10) step();
        chk("frozen_count", int'(count), c0);
        chk("tick_while_stopped", ntick, 5);
        load = 1'b1; load_value = 4'd12;
        step();
        load = 1'b0;
        chk("load_clamp", int'(count), MX);
        chk("load_clamp_wrap", int'(wrap), 0);
        run_button = 1'b0;
        repeat (8) step();
        run_button = 1'b1;
        repeat (8) step();
        chk("run_resumed", int'(running), 1);
        run_button = 1'b0;
        c0 = int'(count);
        repeat (6) step();
        chk("count_moves", int'(int'(count) != c0), 1);
        speed_sel = 1'b0;
        n = 0;
        step();
        while (!tick && n < 20) begin step(); n++; end
        n = 0;
        step(); n++;
        while (!tick && n < 20) begin step(); n++; end
        chk("slow_spacing", n, SD);
        n = 0;
        while (m_pre != 3 && n < 20) begin step(); n++; end
        chk("find_pre_3", m_pre, 3);
        speed_sel = 1'b1;
        step();
        chk("fast_switch_tick", int'(tick), 1);
        step();
        chk("fast_gap", int'(tick), 0);
        step();
        chk("fast_next_tick", int'(tick), 1);
        dir_button = 1'b1;
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_count", int'(count), 0);
        chk("midrst_dir", int'(dir), 0);
        chk("midrst_running", int'(running), 1);
        chk("midrst_tick", int'(tick), 0);
        chk("midrst_wrap", int'(wrap), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        repeat (5) step();
        chk("rst_held_edge5", int'(dir), 0);
        step();
        chk("rst_held_edge6", int'(dir), 1);
        repeat (10) step();
        chk("rst_held_once", int'(dir), 1);
        dir_button = 1'b0;
        repeat (4) step();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
